// File: rtl/if_id_buffer.sv
// if_id_buffer: IF->ID boundary buffer.
// Holds fetched {pc, instruction} pairs in a small FIFO with valid/ready
// handshakes on both sides. The opcode is pre-decoded into the immediate
// format select at push time and stored alongside the entry.
// Optional macro IF_ID_PERF_EN adds stall/bubble performance counters.
module if_id_buffer #(
  parameter int                XLEN     = 32,
  parameter int                DEPTH    = 2,
  parameter logic [XLEN-1:0]   RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            f_valid,
  output logic            f_ready,
  input  logic [XLEN-1:0] f_pc,
  input  logic [XLEN-1:0] f_instr,
  output logic            d_valid,
  input  logic            d_ready,
  output logic [XLEN-1:0] d_pc,
  output logic [XLEN-1:0] d_instr,
  output logic [2:0]      d_imm_type,
`ifdef IF_ID_PERF_EN
  output logic [31:0]     stall_cnt,
  output logic [31:0]     bubble_cnt,
`endif
  output logic            d_illegal
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
  localparam logic [XLEN-1:0] NOP_INSTR = XLEN'(32'h0000_0013);

  // Immediate format encodings consumed by the downstream immediate parser
  localparam logic [2:0] IMM_I  = 3'd0;
  localparam logic [2:0] IMM_U  = 3'd1;
  localparam logic [2:0] IMM_S  = 3'd2;
  localparam logic [2:0] IMM_R  = 3'd3;
  localparam logic [2:0] IMM_SB = 3'd4;
  localparam logic [2:0] IMM_UJ = 3'd5;

  logic [XLEN-1:0] pc_mem    [DEPTH];
  logic [XLEN-1:0] instr_mem [DEPTH];
  logic [2:0]      type_mem  [DEPTH];
  logic            ill_mem   [DEPTH];

  logic [AW-1:0]   rd_ptr;
  logic [AW-1:0]   wr_ptr;
  logic [CW-1:0]   count;

  logic            push;
  logic            pop;
  logic [2:0]      new_type;
  logic            new_ill;

  // Handshake qualification: readiness comes only from registered count,
  // and a flush cycle completes neither side's transfer
  always_comb begin
    f_ready = (count != FULL_COUNT);
    d_valid = (count != '0);
    push    = f_valid & f_ready & ~flush;
    pop     = d_valid & d_ready & ~flush;
  end

  // Opcode pre-decode of the incoming instruction; unknown opcodes are
  // reported as R-type with the illegal flag raised
  always_comb begin
    new_type = IMM_R;
    new_ill  = 1'b0;
    unique case (f_instr[6:0])
      7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011: new_type = IMM_I;
      7'b0110111, 7'b0010111:                         new_type = IMM_U;
      7'b0100011:                                     new_type = IMM_S;
      7'b0110011:                                     new_type = IMM_R;
      7'b1100011:                                     new_type = IMM_SB;
      7'b1101111:                                     new_type = IMM_UJ;
      default: begin
        new_type = IMM_R;
        new_ill  = 1'b1;
      end
    endcase
  end

  // Entry storage: cleared to a NOP at RESET_PC on reset, written on push;
  // flush leaves contents alone since they are unobservable while empty
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem[i]    <= RESET_PC;
        instr_mem[i] <= NOP_INSTR;
        type_mem[i]  <= IMM_I;
        ill_mem[i]   <= 1'b0;
      end
    end else if (push) begin
      pc_mem[wr_ptr]    <= f_pc;
      instr_mem[wr_ptr] <= f_instr;
      type_mem[wr_ptr]  <= new_type;
      ill_mem[wr_ptr]   <= new_ill;
    end
  end

  // Pointer and occupancy tracking; reset beats flush, flush beats traffic,
  // pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Decode-side outputs come straight from the registered head entry
  always_comb begin
    d_pc       = pc_mem[rd_ptr];
    d_instr    = instr_mem[rd_ptr];
    d_imm_type = type_mem[rd_ptr];
    d_illegal  = ill_mem[rd_ptr];
  end

`ifdef IF_ID_PERF_EN
  // Performance counters: fetch stalled by a full buffer, and decode
  // starved by an empty one; only reset clears them, flush does not
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt  <= '0;
      bubble_cnt <= '0;
    end else begin
      if (f_valid && !f_ready) stall_cnt  <= stall_cnt + 32'd1;
      if (d_ready && !d_valid) bubble_cnt <= bubble_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_if_id_buffer.sv
// tb_if_id_buffer: directed self-checking bench for if_id_buffer.
// Define IF_ID_PERF_EN to also exercise the performance counters.
module tb_if_id_buffer;

  localparam int              XLEN  = 32;
  localparam logic [31:0]     RPC   = 32'h0000_0080;

  logic            clk;
  logic            rst;
  logic            flush;
  logic            f_valid;
  logic            f_ready;
  logic [XLEN-1:0] f_pc;
  logic [XLEN-1:0] f_instr;
  logic            d_valid;
  logic            d_ready;
  logic [XLEN-1:0] d_pc;
  logic [XLEN-1:0] d_instr;
  logic [2:0]      d_imm_type;
  logic            d_illegal;
`ifdef IF_ID_PERF_EN
  logic [31:0]     stall_cnt;
  logic [31:0]     bubble_cnt;
`endif

  int tests_run;
  int tests_failed;

  if_id_buffer #(.XLEN(XLEN), .DEPTH(2), .RESET_PC(RPC)) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .f_valid    (f_valid),
    .f_ready    (f_ready),
    .f_pc       (f_pc),
    .f_instr    (f_instr),
    .d_valid    (d_valid),
    .d_ready    (d_ready),
    .d_pc       (d_pc),
    .d_instr    (d_instr),
    .d_imm_type (d_imm_type),
`ifdef IF_ID_PERF_EN
    .stall_cnt  (stall_cnt),
    .bubble_cnt (bubble_cnt),
`endif
    .d_illegal  (d_illegal)
  );

  // Free-running clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge, then settle before driving/sampling
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; f_valid = 1'b0; d_ready = 1'b0;
    f_pc = '0; f_instr = '0;
    tick(); tick();
    rst = 1'b0;
    tick();
    tests_run++;
    if (d_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_d_valid: got %b expected 0", d_valid); end
    tests_run++;
    if (f_ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL reset_f_ready: got %b expected 1", f_ready); end
    tests_run++;
    if (d_pc !== RPC) begin tests_failed++; $display("[TB] FAIL reset_d_pc: got %h expected %h", d_pc, RPC); end
    tests_run++;
    if (d_instr !== 32'h0000_0013) begin tests_failed++; $display("[TB] FAIL reset_d_instr: got %h expected 00000013", d_instr); end
    tests_run++;
    if (d_imm_type !== 3'd0 || d_illegal !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_type: got %0d/%b expected 0/0", d_imm_type, d_illegal); end
  endtask

  task automatic test_single();
    f_valid = 1'b1; f_pc = 32'h100; f_instr = 32'h0050_0093; d_ready = 1'b1;
    tick();
    f_valid = 1'b0;
    tests_run++;
    if (d_valid !== 1'b1) begin tests_failed++; $display("[TB] FAIL single_valid: got %b expected 1", d_valid); end
    tests_run++;
    if (d_pc !== 32'h100 || d_instr !== 32'h0050_0093) begin tests_failed++; $display("[TB] FAIL single_head: got %h/%h expected 00000100/00500093", d_pc, d_instr); end
    tests_run++;
    if (d_imm_type !== 3'd0 || d_illegal !== 1'b0) begin tests_failed++; $display("[TB] FAIL single_type: got %0d/%b expected 0/0", d_imm_type, d_illegal); end
    tick();
    tests_run++;
    if (d_valid !== 1'b0 || f_ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL single_pop: got valid=%b ready=%b expected 0/1", d_valid, f_ready); end
  endtask

  task automatic test_fill_and_drain();
    d_ready = 1'b0;
    f_valid = 1'b1; f_pc = 32'h200; f_instr = 32'h0000_006F;
    tick();
    tests_run++;
    if (f_ready !== 1'b1 || d_valid !== 1'b1) begin tests_failed++; $display("[TB] FAIL fill_one: got ready=%b valid=%b expected 1/1", f_ready, d_valid); end
    f_pc = 32'h204; f_instr = 32'h0000_0063;
    tick();
    tests_run++;
    if (f_ready !== 1'b0) begin tests_failed++; $display("[TB] FAIL fill_full: got f_ready=%b expected 0", f_ready); end
    f_pc = 32'h208; f_instr = 32'h0000_0023;
    tick();
    tests_run++;
    if (f_ready !== 1'b0 || d_pc !== 32'h200 || d_imm_type !== 3'd5) begin tests_failed++; $display("[TB] FAIL fill_hold: got ready=%b pc=%h type=%0d expected 0/00000200/5", f_ready, d_pc, d_imm_type); end
    // Full with pop and push both presented: pop only
    d_ready = 1'b1;
    tick();
    tests_run++;
    if (f_ready !== 1'b1 || d_valid !== 1'b1 || d_pc !== 32'h204 || d_imm_type !== 3'd4) begin tests_failed++; $display("[TB] FAIL full_pop_only: got ready=%b valid=%b pc=%h type=%0d expected 1/1/00000204/4", f_ready, d_valid, d_pc, d_imm_type); end
    // Simultaneous push and pop: sw enters, beq leaves
    tick();
    f_valid = 1'b0;
    tests_run++;
    if (f_ready !== 1'b1 || d_valid !== 1'b1 || d_pc !== 32'h208 || d_imm_type !== 3'd2) begin tests_failed++; $display("[TB] FAIL push_pop: got ready=%b valid=%b pc=%h type=%0d expected 1/1/00000208/2", f_ready, d_valid, d_pc, d_imm_type); end
    tick();
    tests_run++;
    if (d_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL drain_empty: got d_valid=%b expected 0", d_valid); end
  endtask

  task automatic test_flush();
    d_ready = 1'b0;
    f_valid = 1'b1; f_pc = 32'h300; f_instr = 32'h0000_0013;
    tick();
    f_pc = 32'h304; f_instr = 32'h0000_0033;
    tick();
    f_pc = 32'h308; f_instr = 32'h0000_0037; flush = 1'b1; d_ready = 1'b1;
    tick();
    flush = 1'b0; f_valid = 1'b0; d_ready = 1'b0;
    tests_run++;
    if (d_valid !== 1'b0 || f_ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL flush_full: got valid=%b ready=%b expected 0/1", d_valid, f_ready); end
    // One entry buffered and fetch ready: the incoming entry is still dropped
    f_valid = 1'b1; f_pc = 32'h310; f_instr = 32'h0000_0013;
    tick();
    f_pc = 32'h314; flush = 1'b1;
    tick();
    flush = 1'b0; f_valid = 1'b0;
    tick();
    tests_run++;
    if (d_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL flush_drop: got d_valid=%b expected 0", d_valid); end
    // Refetch after redirect lands normally
    f_valid = 1'b1; f_pc = 32'h400; f_instr = 32'h1234_5037;
    tick();
    f_valid = 1'b0;
    tests_run++;
    if (d_valid !== 1'b1 || d_pc !== 32'h400 || d_imm_type !== 3'd1) begin tests_failed++; $display("[TB] FAIL flush_refetch: got valid=%b pc=%h type=%0d expected 1/00000400/1", d_valid, d_pc, d_imm_type); end
    d_ready = 1'b1;
    tick();
    d_ready = 1'b0;
  endtask

  task automatic test_predecode();
    logic [31:0] instrs [8];
    logic [2:0]  types  [8];
    logic        ills   [8];
    instrs[0] = 32'h0000_007F; types[0] = 3'd3; ills[0] = 1'b1;
    instrs[1] = 32'h0000_0017; types[1] = 3'd1; ills[1] = 1'b0;
    instrs[2] = 32'h0000_0067; types[2] = 3'd0; ills[2] = 1'b0;
    instrs[3] = 32'h0000_0073; types[3] = 3'd0; ills[3] = 1'b0;
    instrs[4] = 32'h0000_0003; types[4] = 3'd0; ills[4] = 1'b0;
    instrs[5] = 32'h0020_81B3; types[5] = 3'd3; ills[5] = 1'b0;
    instrs[6] = 32'h0000_000B; types[6] = 3'd3; ills[6] = 1'b1;
    instrs[7] = 32'h0000_00E3; types[7] = 3'd4; ills[7] = 1'b0;
    d_ready = 1'b1; f_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      f_pc = 32'h500 + 32'(i * 4);
      f_instr = instrs[i];
      tick();
      tests_run++;
      if (d_valid !== 1'b1 || d_instr !== instrs[i] || d_imm_type !== types[i] || d_illegal !== ills[i]) begin
        tests_failed++;
        $display("[TB] FAIL predecode_%0d: got valid=%b instr=%h type=%0d ill=%b expected 1/%h/%0d/%b",
                 i, d_valid, d_instr, d_imm_type, d_illegal, instrs[i], types[i], ills[i]);
      end
    end
    f_valid = 1'b0;
    tick();
    d_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    f_valid = 1'b1; f_pc = 32'h600; f_instr = 32'h0000_0023;
    tick();
    f_valid = 1'b1; rst = 1'b1; flush = 1'b1;
    tick();
    rst = 1'b0; flush = 1'b0; f_valid = 1'b0;
    tests_run++;
    if (d_valid !== 1'b0 || f_ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL rst_mid_flags: got valid=%b ready=%b expected 0/1", d_valid, f_ready); end
    tests_run++;
    if (d_pc !== RPC || d_instr !== 32'h0000_0013 || d_imm_type !== 3'd0) begin tests_failed++; $display("[TB] FAIL rst_mid_head: got pc=%h instr=%h type=%0d expected %h/00000013/0", d_pc, d_instr, d_imm_type, RPC); end
  endtask

`ifdef IF_ID_PERF_EN
  task automatic test_perf();
    rst = 1'b1; f_valid = 1'b0; d_ready = 1'b0; flush = 1'b0;
    tick();
    rst = 1'b0;
    f_valid = 1'b1; f_pc = 32'h700; f_instr = 32'h0000_0013;
    tick();
    tick();
    tick(); tick(); tick();
    tests_run++;
    if (stall_cnt !== 32'd3 || bubble_cnt !== 32'd0) begin tests_failed++; $display("[TB] FAIL perf_stall: got stall=%0d bubble=%0d expected 3/0", stall_cnt, bubble_cnt); end
    f_valid = 1'b0; d_ready = 1'b1; flush = 1'b0;
    tick(); tick(); tick();
    d_ready = 1'b0;
    tests_run++;
    if (stall_cnt !== 32'd3 || bubble_cnt !== 32'd1) begin tests_failed++; $display("[TB] FAIL perf_bubble: got stall=%0d bubble=%0d expected 3/1", stall_cnt, bubble_cnt); end
  endtask
`endif

  // Scenario sequence
  initial begin
    tests_run = 0;
    tests_failed = 0;
    test_reset();
    test_single();
    test_fill_and_drain();
    test_flush();
    test_predecode();
    test_reset_mid();
`ifdef IF_ID_PERF_EN
    test_perf();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
